plic_gateway: RTL and testbench

Per-source interrupt gateway for the PLIC. Converts raw, asynchronous interrupt lines into one pending bit per source (`ip_o[i]`), which feeds the `ip_i` input of each source's cell column in the source-target matrix. The gateway enforces the claim/complete handshake, so a source cannot raise a new request until its previous one has completed. It supports level- and rising-edge-triggered sources, with a saturating count of queued edges for edge sources.

---
 rtl/plic_gateway.sv | 102 ++++++++++
 tb/tb_plic_gateway.sv | 248 ++++++++++++++++++++++++
 2 files changed

// File: rtl/plic_gateway.sv
// plic_gateway: per-source interrupt gateway for the PLIC.
// Synchronises raw interrupt lines, enforces the claim/complete handshake and
// queues rising edges (saturating) for edge-triggered sources.
module plic_gateway #(
  parameter int unsigned SOURCES           = 8,
  parameter int unsigned MAX_PENDING_COUNT = 8,
  parameter int unsigned PCNT_BITS         = 4
) (
  input  logic               rst_ni,
  input  logic               clk_i,
  input  logic [SOURCES-1:0] src_i,
  input  logic [SOURCES-1:0] el_i,
  input  logic [SOURCES-1:0] claim_i,
  input  logic [SOURCES-1:0] complete_i,
  output logic [SOURCES-1:0] ip_o
);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    PEND = 2'd1,
    BUSY = 2'd2
  } state_e;

  localparam logic [PCNT_BITS-1:0] CNT_MAX = PCNT_BITS'(MAX_PENDING_COUNT);
  localparam logic [PCNT_BITS-1:0] CNT_ONE = PCNT_BITS'(1);

  logic [SOURCES-1:0] f1_q;
  logic [SOURCES-1:0] s_q;
  logic [SOURCES-1:0] s_d_q;
  logic [SOURCES-1:0] edge_w;

  // Two-flop synchroniser plus one delayed copy for rising-edge detection.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      f1_q  <= '0;
      s_q   <= '0;
      s_d_q <= '0;
    end else begin
      f1_q  <= src_i;
      s_q   <= f1_q;
      s_d_q <= s_q;
    end
  end

  assign edge_w = s_q & ~s_d_q;

  for (genvar i = 0; i < SOURCES; i++) begin : g_src
    state_e               state_q;
    logic [PCNT_BITS-1:0] cnt_q;
    logic                 ip_q;
    logic                 req;
    logic                 take;

    // Request term: level follows the synchronised line, edge uses fresh edge or backlog.
    always_comb begin
      req  = el_i[i] ? (edge_w[i] | (cnt_q != '0)) : s_q[i];
      take = (state_q == IDLE) && req;
    end

    // Handshake FSM; ip_q is registered alongside the state so it equals (state == PEND).
    always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) begin
        state_q <= IDLE;
        ip_q    <= 1'b0;
      end else begin
        unique case (state_q)
          IDLE: if (req) begin
            state_q <= PEND;
            ip_q    <= 1'b1;
          end
          PEND: if (claim_i[i]) begin
            state_q <= BUSY;
            ip_q    <= 1'b0;
          end
          BUSY: if (complete_i[i]) begin
            state_q <= IDLE;
          end
          default: begin
            state_q <= IDLE;
            ip_q    <= 1'b0;
          end
        endcase
      end
    end

    // Queued-edge counter: an edge consumed by IDLE->PEND in the same cycle is not counted.
    always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) begin
        cnt_q <= '0;
      end else if (!el_i[i]) begin
        cnt_q <= '0;
      end else if (take && !edge_w[i]) begin
        cnt_q <= cnt_q - CNT_ONE;
      end else if (edge_w[i] && !take && (cnt_q < CNT_MAX)) begin
        cnt_q <= cnt_q + CNT_ONE;
      end
    end

    assign ip_o[i] = ip_q;
  end

endmodule

// File: tb/tb_plic_gateway.sv
// tb_plic_gateway: directed scoreboard bench for plic_gateway (8 sources, saturation 8).
module tb_plic_gateway;

  logic       rst_ni;
  logic       clk_i;
  logic [7:0] src_i;
  logic [7:0] el_i;
  logic [7:0] claim_i;
  logic [7:0] complete_i;
  logic [7:0] ip_o;

  int unsigned n_cmp = 0;
  int unsigned n_err = 0;

  logic [7:0] exp_q[$];
  string      tag_q[$];

  plic_gateway #(
    .SOURCES          (8),
    .MAX_PENDING_COUNT(8),
    .PCNT_BITS        (4)
  ) dut (
    .rst_ni    (rst_ni),
    .clk_i     (clk_i),
    .src_i     (src_i),
    .el_i      (el_i),
    .claim_i   (claim_i),
    .complete_i(complete_i),
    .ip_o      (ip_o)
  );

  initial clk_i = 1'b0;
  always #5 clk_i = ~clk_i;

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  task automatic tick();
    @(posedge clk_i);
    #1;
  endtask

  task automatic push(input logic [7:0] exp, input string tag);
    exp_q.push_back(exp);
    tag_q.push_back(tag);
  endtask

  task automatic score();
    logic [7:0] e;
    string      t;
    e = exp_q.pop_front();
    t = tag_q.pop_front();
    n_cmp++;
    assert (ip_o === e) else begin
      n_err++;
      $error("FAIL %s: ip_o=%h expected %h", t, ip_o, e);
    end
  endtask

  // Expectation for ip_o after the next active edge.
  task automatic cyc(input logic [7:0] exp, input string tag);
    push(exp, tag);
    tick();
    score();
  endtask

  task automatic claim(input logic [7:0] mask, input logic [7:0] exp, input string tag);
    claim_i = mask;
    cyc(exp, tag);
    claim_i = '0;
  endtask

  task automatic complete(input logic [7:0] mask, input logic [7:0] exp, input string tag);
    complete_i = mask;
    cyc(exp, tag);
    complete_i = '0;
  endtask

  // 2 cycles high, 2 cycles low on source k, ip_o expected constant throughout.
  task automatic pulse(input int unsigned k, input logic [7:0] exp, input string tag);
    src_i[k] = 1'b1;
    cyc(exp, tag);
    cyc(exp, tag);
    src_i[k] = 1'b0;
    cyc(exp, tag);
    cyc(exp, tag);
  endtask

  // Edge-mode source 0 from IDLE with empty queue: deliver one pulse and claim it.
  task automatic deliver0_and_claim(input string tag);
    src_i[0] = 1'b1;
    cyc(8'h00, tag);
    cyc(8'h00, tag);
    src_i[0] = 1'b0;
    cyc(8'h01, tag);
    cyc(8'h01, tag);
    claim(8'h01, 8'h00, tag);
  endtask

  initial begin
    rst_ni     = 1'b0;
    src_i      = '0;
    el_i       = '0;
    claim_i    = '0;
    complete_i = '0;
    #3;
    push(8'h00, "reset_ip");
    score();
    #9;
    rst_ni = 1'b1;
    tick();

    // Level round trip on source 0.
    src_i[0] = 1'b1;
    cyc(8'h00, "lvl_lat1");
    cyc(8'h00, "lvl_lat2");
    cyc(8'h01, "lvl_lat3");
    claim(8'h01, 8'h00, "lvl_claim");
    cyc(8'h00, "lvl_busy");
    complete(8'h01, 8'h00, "lvl_idle_gap");
    cyc(8'h01, "lvl_repend");
    src_i[0] = 1'b0;
    cyc(8'h01, "lvl_latched");
    cyc(8'h01, "lvl_latched");
    claim(8'h01, 8'h00, "lvl_claim2");
    complete(8'h01, 8'h00, "lvl_done");
    cyc(8'h00, "lvl_quiet");
    cyc(8'h00, "lvl_quiet");

    // Edge queueing: 3 edges while BUSY yield exactly 3 deliveries.
    el_i[0] = 1'b1;
    deliver0_and_claim("edge_first");
    for (int n = 0; n < 3; n++) pulse(0, 8'h00, "edge_queue_busy");
    for (int n = 0; n < 3; n++) begin
      complete(8'h01, 8'h00, "edge_gap");
      cyc(8'h01, "edge_deliver");
      claim(8'h01, 8'h00, "edge_claim");
    end
    complete(8'h01, 8'h00, "edge_drained");
    cyc(8'h00, "edge_drained");
    cyc(8'h00, "edge_drained");

    // Saturation: 10 edges while BUSY, only 8 delivered.
    deliver0_and_claim("sat_first");
    for (int n = 0; n < 10; n++) pulse(0, 8'h00, "sat_queue_busy");
    for (int n = 0; n < 8; n++) begin
      complete(8'h01, 8'h00, "sat_gap");
      cyc(8'h01, "sat_deliver");
      claim(8'h01, 8'h00, "sat_claim");
    end
    complete(8'h01, 8'h00, "sat_drained");
    cyc(8'h00, "sat_drained");
    cyc(8'h00, "sat_drained");

    // Handshake corners.
    complete(8'h01, 8'h00, "stray_complete_idle");
    cyc(8'h00, "stray_complete_idle");
    src_i[0] = 1'b1;
    cyc(8'h00, "hs_lat");
    cyc(8'h00, "hs_lat");
    src_i[0] = 1'b0;
    cyc(8'h01, "hs_pend");
    claim_i    = 8'h01;
    complete_i = 8'h01;
    cyc(8'h00, "claim_complete_same");
    claim_i    = '0;
    complete_i = '0;
    pulse(0, 8'h00, "complete_not_remembered");
    claim(8'h01, 8'h00, "stray_claim_busy");
    cyc(8'h00, "stray_claim_busy");
    complete(8'h01, 8'h00, "hs_gap");
    cyc(8'h01, "hs_queued_deliver");
    claim(8'h01, 8'h00, "hs_claim");
    complete(8'h01, 8'h00, "hs_done");
    cyc(8'h00, "hs_done");

    // Reset mid-operation: source 0 BUSY with 5 queued, source 1 level pending.
    deliver0_and_claim("rst_setup");
    for (int n = 0; n < 5; n++) pulse(0, 8'h00, "rst_queue");
    src_i[1] = 1'b1;
    cyc(8'h00, "rst_lvl1");
    cyc(8'h00, "rst_lvl1");
    cyc(8'h02, "rst_lvl1_pend");
    rst_ni = 1'b0;
    #1;
    push(8'h00, "rst_async_clear");
    score();
    #3;
    rst_ni = 1'b1;
    cyc(8'h00, "rst_release_lat1");
    cyc(8'h00, "rst_release_lat2");
    cyc(8'h02, "rst_release_lat3");
    cyc(8'h02, "rst_cnt_cleared");
    claim(8'h02, 8'h00, "rst_claim1");
    src_i[1] = 1'b0;
    cyc(8'h00, "rst_cleanup");
    cyc(8'h00, "rst_cleanup");
    cyc(8'h00, "rst_cleanup");
    complete(8'h02, 8'h00, "rst_cleanup");
    cyc(8'h00, "rst_cleanup");

    // Mode switch: BUSY with 4 queued, level mode for one edge clears the queue.
    deliver0_and_claim("mode_setup");
    for (int n = 0; n < 4; n++) pulse(0, 8'h00, "mode_queue");
    el_i[0] = 1'b0;
    cyc(8'h00, "mode_clear");
    el_i[0] = 1'b1;
    cyc(8'h00, "mode_still_busy");
    complete(8'h01, 8'h00, "mode_gap");
    cyc(8'h00, "mode_no_backlog");
    cyc(8'h00, "mode_no_backlog");
    el_i[0]  = 1'b0;
    src_i[0] = 1'b1;
    cyc(8'h00, "mode_lvl_lat");
    cyc(8'h00, "mode_lvl_lat");
    cyc(8'h01, "mode_lvl_pend");
    claim(8'h01, 8'h00, "mode_lvl_claim");
    src_i[0] = 1'b0;
    cyc(8'h00, "mode_lvl_busy");
    cyc(8'h00, "mode_lvl_busy");
    complete(8'h01, 8'h00, "mode_lvl_done");
    cyc(8'h00, "mode_lvl_done");

    // Independence: sources 0 and 7 in edge mode, interleaved by one cycle.
    el_i = 8'h81;
    src_i[0] = 1'b1;
    cyc(8'h00, "ind_a");
    src_i[7] = 1'b1;
    cyc(8'h00, "ind_b");
    src_i[0] = 1'b0;
    cyc(8'h01, "ind_src0_pend");
    src_i[7] = 1'b0;
    cyc(8'h81, "ind_both_pend");
    claim(8'h01, 8'h80, "ind_claim0_only");
    claim(8'h80, 8'h00, "ind_claim7");
    complete(8'h80, 8'h00, "ind_complete7");
    cyc(8'h00, "ind_quiet");
    complete(8'h01, 8'h00, "ind_complete0");
    cyc(8'h00, "ind_quiet");

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
